// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the shared memory-unit bus: start/busy sequencing,
// round-robin or fixed-priority selection, init gating and a per-transaction watchdog.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned RR      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_init_done,
    input  logic        m0_req,
    input  logic [26:0] m0_addr,
    input  logic [31:0] m0_data,
    input  logic        m0_we,
    output logic        m0_ack,
    output logic [31:0] m0_q,
    input  logic        m1_req,
    input  logic [26:0] m1_addr,
    input  logic [31:0] m1_data,
    input  logic        m1_we,
    output logic        m1_ack,
    output logic [31:0] m1_q,
    output logic        mem_start,
    output logic [26:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_we,
    input  logic        mem_busy,
    input  logic [31:0] mem_q,
    output logic        grant,
    output logic        timeout_err
);

    localparam int unsigned     WDW     = $clog2(TIMEOUT);
    localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t          r_state, w_state;
    logic            r_start, w_start;
    logic [26:0]     r_addr,  w_addr;
    logic [31:0]     r_data,  w_data;
    logic            r_we,    w_we;
    logic            r_ack0,  w_ack0;
    logic            r_ack1,  w_ack1;
    logic [31:0]     r_q0,    w_q0;
    logic [31:0]     r_q1,    w_q1;
    logic            r_grant, w_grant;
    logic            r_terr,  w_terr;
    logic            r_last,  w_last;
    logic [WDW-1:0]  r_wd,    w_wd;
    logic [WDW-1:0]  w_wd_inc;
    logic            w_expire;
    logic            w_sel;
    logic            w_finish;
    logic            w_abort;
    logic [31:0]     w_ret;

    always_comb begin
        w_state  = r_state;
        w_start  = r_start;
        w_addr   = r_addr;
        w_data   = r_data;
        w_we     = r_we;
        w_ack0   = 1'b0;
        w_ack1   = 1'b0;
        w_q0     = r_q0;
        w_q1     = r_q1;
        w_grant  = r_grant;
        w_terr   = r_terr;
        w_last   = r_last;
        w_wd     = r_wd;
        w_wd_inc = r_wd + WDW'(1);
        w_expire = (w_wd_inc == WD_LAST);
        w_sel    = 1'b0;
        w_finish = 1'b0;
        w_abort  = 1'b0;
        w_ret    = '0;

        case (r_state)
            S_IDLE: begin
                if (mem_init_done && (m0_req || m1_req)) begin
                    // On a tie, round-robin favours whoever was not served last
                    w_sel   = m1_req && (!m0_req || ((RR != 0) && !r_last));
                    w_addr  = w_sel ? m1_addr : m0_addr;
                    w_data  = w_sel ? m1_data : m0_data;
                    w_we    = w_sel ? m1_we   : m0_we;
                    w_start = 1'b1;
                    w_grant = w_sel;
                    w_wd    = '0;
                    w_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_wd = w_wd_inc;
                if (w_expire)
                    w_abort = 1'b1;
                else if (mem_busy)
                    w_state = S_WAIT;
            end
            S_WAIT: begin
                w_wd = w_wd_inc;
                // Busy falling on the expiry edge still counts as a normal completion
                if (!mem_busy)
                    w_finish = 1'b1;
                else if (w_expire)
                    w_abort = 1'b1;
            end
            default: w_state = S_IDLE;
        endcase

        if (w_finish || w_abort) begin
            w_ret   = w_finish ? mem_q : '0;
            w_start = 1'b0;
            w_state = S_IDLE;
            w_last  = r_grant;
            if (r_grant) begin
                w_ack1 = 1'b1;
                w_q1   = w_ret;
            end else begin
                w_ack0 = 1'b1;
                w_q0   = w_ret;
            end
            if (w_abort)
                w_terr = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_start <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_we    <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_q0    <= '0;
            r_q1    <= '0;
            r_grant <= 1'b0;
            r_terr  <= 1'b0;
            r_last  <= 1'b1;
            r_wd    <= '0;
        end else begin
            r_state <= w_state;
            r_start <= w_start;
            r_addr  <= w_addr;
            r_data  <= w_data;
            r_we    <= w_we;
            r_ack0  <= w_ack0;
            r_ack1  <= w_ack1;
            r_q0    <= w_q0;
            r_q1    <= w_q1;
            r_grant <= w_grant;
            r_terr  <= w_terr;
            r_last  <= w_last;
            r_wd    <= w_wd;
        end
    end

    assign mem_start   = r_start;
    assign mem_addr    = r_addr;
    assign mem_data    = r_data;
    assign mem_we      = r_we;
    assign m0_ack      = r_ack0;
    assign m1_ack      = r_ack1;
    assign m0_q        = r_q0;
    assign m1_q        = r_q1;
    assign grant       = r_grant;
    assign timeout_err = r_terr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance share the requester
// stimulus; a transaction-level model predicts every output cycle by cycle.
module tb_mem_arbiter;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        init;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [26:0] m0_addr, m1_addr;
    logic [31:0] m0_data, m1_data;

    logic [1:0]  ack0, ack1, mstart, mwe, grant, terr, busy;
    logic [31:0] q0 [2];
    logic [31:0] q1 [2];
    logic [31:0] mdata [2];
    logic [31:0] mq [2];
    logic [26:0] maddr [2];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int mem_k    = 1;
    bit mem_dead = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [26:0] a);
        if (a == 27'hC02622) return 32'h0000ABCD;
        return {a, 5'd0} ^ 32'h1357_9BDF;
    endfunction

    assign mq[0] = memf(maddr[0]);
    assign mq[1] = memf(maddr[1]);

    mem_arbiter #(.TIMEOUT(TO), .RR(1)) u_rr (
        .clk(clk), .reset(reset), .mem_init_done(init),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_data(m0_data), .m0_we(m0_we),
        .m0_ack(ack0[0]), .m0_q(q0[0]),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_data(m1_data), .m1_we(m1_we),
        .m1_ack(ack1[0]), .m1_q(q1[0]),
        .mem_start(mstart[0]), .mem_addr(maddr[0]), .mem_data(mdata[0]), .mem_we(mwe[0]),
        .mem_busy(busy[0]), .mem_q(mq[0]), .grant(grant[0]), .timeout_err(terr[0])
    );

    mem_arbiter #(.TIMEOUT(TO), .RR(0)) u_fp (
        .clk(clk), .reset(reset), .mem_init_done(init),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_data(m0_data), .m0_we(m0_we),
        .m0_ack(ack0[1]), .m0_q(q0[1]),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_data(m1_data), .m1_we(m1_we),
        .m1_ack(ack1[1]), .m1_q(q1[1]),
        .mem_start(mstart[1]), .mem_addr(maddr[1]), .mem_data(mdata[1]), .mem_we(mwe[1]),
        .mem_busy(busy[1]), .mem_q(mq[1]), .grant(grant[1]), .timeout_err(terr[1])
    );

    // Memory unit: busy rises the edge after it sees start, stays up mem_k cycles,
    // then waits for start to drop before accepting another command.
    int ms [2];
    int mcnt [2];
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                ms[i]   <= 0;
                busy[i] <= 1'b0;
                mcnt[i] <= 0;
            end else begin
                case (ms[i])
                    0: if (mstart[i] && !mem_dead) begin
                        ms[i]   <= 1;
                        busy[i] <= 1'b1;
                        mcnt[i] <= mem_k;
                    end
                    1: begin
                        mcnt[i] <= mcnt[i] - 1;
                        if (mcnt[i] == 1) begin
                            busy[i] <= 1'b0;
                            ms[i]   <= 2;
                        end
                    end
                    default: if (!mstart[i]) ms[i] <= 0;
                endcase
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: one transaction in flight per instance; completion time is
    // computed arithmetically from the memory latency and the watchdog limit.
    bit          e_act [2];
    int          e_own [2];
    int          e_done [2];
    bit          e_to [2];
    int          e_last [2];
    logic [26:0] e_addr [2];
    logic [31:0] e_data [2];
    logic [31:0] e_q0 [2];
    logic [31:0] e_q1 [2];
    bit          e_we [2];
    bit          e_start [2];
    bit          e_ack0 [2];
    bit          e_ack1 [2];
    bit          e_terr [2];
    int          e_grant [2];

    task automatic model_step();
        int w;
        logic [31:0] rq;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                e_act[i] = 0; e_start[i] = 0; e_addr[i] = '0; e_data[i] = '0; e_we[i] = 0;
                e_ack0[i] = 0; e_ack1[i] = 0; e_q0[i] = '0; e_q1[i] = '0;
                e_grant[i] = 0; e_terr[i] = 0; e_last[i] = 1;
            end else begin
                e_ack0[i] = 0;
                e_ack1[i] = 0;
                if (e_act[i] && cyc == e_done[i]) begin
                    rq = e_to[i] ? 32'h0 : memf(e_addr[i]);
                    if (e_own[i] == 0) begin e_ack0[i] = 1; e_q0[i] = rq; end
                    else               begin e_ack1[i] = 1; e_q1[i] = rq; end
                    if (e_to[i]) e_terr[i] = 1;
                    e_last[i]  = e_own[i];
                    e_act[i]   = 0;
                    e_start[i] = 0;
                end else if (!e_act[i] && init && (m0_req || m1_req)) begin
                    if (m0_req && m1_req) w = (i == 0) ? ((e_last[i] == 0) ? 1 : 0) : 0;
                    else                  w = m1_req ? 1 : 0;
                    e_own[i]   = w;
                    e_act[i]   = 1;
                    e_start[i] = 1;
                    e_grant[i] = w;
                    e_addr[i]  = (w == 1) ? m1_addr : m0_addr;
                    e_data[i]  = (w == 1) ? m1_data : m0_data;
                    e_we[i]    = (w == 1) ? m1_we : m0_we;
                    if (mem_dead || (mem_k + 2 > int'(TO) - 1)) begin
                        e_done[i] = cyc + int'(TO) - 1;
                        e_to[i]   = 1;
                    end else begin
                        e_done[i] = cyc + mem_k + 2;
                        e_to[i]   = 0;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        string p;
        for (int i = 0; i < 2; i++) begin
            p = (i == 0) ? "rr" : "fp";
            chk({p, ".mem_start"},   32'(mstart[i]), 32'(e_start[i]));
            chk({p, ".mem_addr"},    32'(maddr[i]),  32'(e_addr[i]));
            chk({p, ".mem_data"},    mdata[i],       e_data[i]);
            chk({p, ".mem_we"},      32'(mwe[i]),    32'(e_we[i]));
            chk({p, ".m0_ack"},      32'(ack0[i]),   32'(e_ack0[i]));
            chk({p, ".m1_ack"},      32'(ack1[i]),   32'(e_ack1[i]));
            chk({p, ".m0_q"},        q0[i],          e_q0[i]);
            chk({p, ".m1_q"},        q1[i],          e_q1[i]);
            chk({p, ".grant"},       32'(grant[i]),  32'(e_grant[i]));
            chk({p, ".timeout_err"}, 32'(terr[i]),   32'(e_terr[i]));
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare_all();
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_start(output int at);
        int n = 0;
        while (!mstart[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!mstart[0]) chk("start_wait_expired", 32'(n), 32'd0);
        at = cyc;
    endtask

    task automatic wait_ack(output int at);
        int n = 0;
        while (!(ack0[0] || ack1[0]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!(ack0[0] || ack1[0])) chk("ack_wait_expired", 32'(n), 32'd0);
        at = cyc;
    endtask

    initial begin
        int g, a;
        logic [5:0] seq_rr, seq_fp;
        reset = 1'b1; init = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_data = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_data = '0;
        tick(3);
        reset = 1'b0;

        // Init gating, then a single read with a one-cycle busy
        mem_k = 1;
        m0_addr = 27'hC02622; m0_data = 32'h1111_2222; m0_req = 1;
        tick(20);
        chk("t1_gated_start", 32'(mstart[0]), 32'd0);
        chk("t1_gated_ack",   32'(ack0[0]),   32'd0);
        init = 1'b1;
        tick(1);
        g = cyc;
        chk("t1_start", 32'(mstart[0]), 32'd1);
        chk("t1_addr",  32'(maddr[0]),  32'h00C02622);
        wait_ack(a);
        chk("t2_latency", 32'(a - g), 32'd3);
        chk("t2_q",       q0[0],      32'h0000ABCD);
        m0_req = 0;

        // Requester 1 write with five busy cycles
        tick(2);
        mem_k = 5;
        m1_addr = 27'h000100; m1_data = 32'hDEADBEEF; m1_we = 1; m1_req = 1;
        wait_start(g);
        chk("t4_we",   32'(mwe[0]), 32'd1);
        chk("t4_data", mdata[0],    32'hDEADBEEF);
        wait_ack(a);
        chk("t4_latency", 32'(a - g), 32'd7);
        chk("t4_ack1",    32'(ack1[0]), 32'd1);
        chk("t4_q",       q1[0],        32'h1357BBDF);
        m1_req = 0; m1_we = 0;

        // Both requesters held: six back-to-back transactions
        tick(2);
        mem_k = 1;
        m0_addr = 27'h10; m0_data = 32'hA0A0_0010;
        m1_addr = 27'h20; m1_data = 32'hB0B0_0020;
        m0_req = 1; m1_req = 1;
        seq_rr = '0; seq_fp = '0;
        for (int n = 0; n < 6; n++) begin
            wait_ack(a);
            seq_rr[n] = ack1[0];
            seq_fp[n] = ack1[1];
            if (n == 5) begin m0_req = 0; m1_req = 0; end
            tick(1);
        end
        chk("t3_rr_sequence", 32'(seq_rr), 32'h2A);
        chk("t3_fp_sequence", 32'(seq_fp), 32'h00);

        // Busy falls on the expiry edge: normal completion
        tick(2);
        mem_k = 13;
        m0_addr = 27'h3; m0_req = 1;
        wait_start(g);
        wait_ack(a);
        chk("t5_edge_latency", 32'(a - g), 32'd15);
        chk("t5_edge_terr",    32'(terr[0]), 32'd0);
        chk("t5_edge_q",       q0[0], 32'h13579BBF);
        m0_req = 0;

        // Busy held one cycle too long: abort
        tick(2);
        mem_k = 14;
        m0_req = 1;
        wait_start(g);
        wait_ack(a);
        chk("t5_late_latency", 32'(a - g), 32'd15);
        chk("t5_late_terr",    32'(terr[0]), 32'd1);
        chk("t5_late_q",       q0[0], 32'd0);
        m0_req = 0;

        // Memory never responds
        tick(2);
        mem_dead = 1;
        m0_addr = 27'hC02622; m0_req = 1;
        wait_start(g);
        wait_ack(a);
        chk("t5_dead_latency", 32'(a - g), 32'd15);
        chk("t5_dead_q",       q0[0], 32'd0);
        m0_req = 0;
        tick(1);
        mem_dead = 0;

        // Normal transaction after an abort; the error flag stays set
        tick(2);
        mem_k = 2;
        m0_addr = 27'h4; m0_req = 1;
        wait_start(g);
        wait_ack(a);
        chk("t5_after_latency", 32'(a - g), 32'd4);
        chk("t5_after_q",       q0[0], 32'h13579B5F);
        chk("t5_after_terr",    32'(terr[0]), 32'd1);
        m0_req = 0;

        // Reset while waiting on busy
        tick(2);
        mem_k = 5;
        m1_addr = 27'h55; m1_req = 1;
        wait_start(g);
        tick(3);
        chk("t6_pre_grant", 32'(grant[0]), 32'd1);
        reset = 1; m1_req = 0;
        tick(1);
        for (int i = 0; i < 2; i++) begin
            chk("t6_start", 32'(mstart[i]), 32'd0);
            chk("t6_ack",   32'(ack1[i]),   32'd0);
            chk("t6_terr",  32'(terr[i]),   32'd0);
            chk("t6_grant", 32'(grant[i]),  32'd0);
        end
        reset = 0;
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
